// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the
// CPU memory stage (cpu_*) and a debug/DMA loader (dma_*).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_ack   CPU requester
//   dma_req/we/addr/wdata -> dma_rdata, dma_ack   loader requester
//   gnt               one-hot owner {dma,cpu}, 0 when idle
//   mem_en/we/addr/wdata -> mem_rdata            memory side
//
// Parameters: AW, DW, MEM_LAT (0..15, cycles from mem_en to mem_rdata).
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking;
// otherwise the CPU always wins ties (fixed priority).
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [1:0]    gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state;
    logic [3:0] cnt;
    logic       lat_we;
    logic       pick_dma;

`ifdef MEM_ARB_RR_EN
    // Set when the CPU won the last grant, so the loader wins the next tie.
    logic prefer_dma;

    always_comb begin
        pick_dma = dma_req & (~cpu_req | prefer_dma);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_dma <= 1'b0;
        end else if (state == IDLE && (cpu_req || dma_req)) begin
            prefer_dma <= ~pick_dma;
        end
    end
`else
    always_comb begin
        pick_dma = dma_req & ~cpu_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            gnt       <= 2'b00;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        gnt       <= pick_dma ? 2'b10 : 2'b01;
                        lat_we    <= pick_dma ? dma_we : cpu_we;
                        mem_we    <= pick_dma ? dma_we : cpu_we;
                        mem_addr  <= pick_dma ? dma_addr : cpu_addr;
                        mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        cnt       <= LAT;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Write strobe lives only in the first BUSY cycle.
                    mem_we <= 1'b0;
                    if (cnt == 4'd0) begin
                        mem_en <= 1'b0;
                        state  <= DONE;
                        if (gnt[1]) begin
                            dma_ack <= 1'b1;
                            if (!lat_we) begin
                                dma_rdata <= mem_rdata;
                            end
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!lat_we) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a
// queue of expected accesses checked by an independent monitor.
module tb_mem_port_arbiter;

    localparam int LAT = 1;

    typedef struct {
        bit          dma;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [31:0] dma_addr = '0;
    logic [31:0] dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic [1:0]  gnt;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word array, registered read for LAT=1.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        rd_q <= mem[mem_addr[9:2]];
    end
    assign mem_rdata = (LAT == 0) ? mem[mem_addr[9:2]] : rd_q;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    exp_t sb[$];
    logic [31:0] last_cpu = '0;
    logic [31:0] last_dma = '0;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor
    logic [1:0] prev_gnt = 2'b00;
    int g_cyc = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    always @(negedge clk) begin
        exp_t cur;
        if (rst) begin
            en_cnt = 0;
            we_cnt = 0;
        end else begin
            if (mem_en) en_cnt++;
            if (mem_we) we_cnt++;
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                chk("grant_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    cur = sb[0];
                    chk("grant_owner", 32'(gnt), cur.dma ? 2 : 1);
                    chk("grant_addr", mem_addr, cur.addr);
                    chk("grant_we", 32'(mem_we), 32'(cur.we));
                    if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
                    g_cyc = cyc;
                end
            end
            if (cpu_ack || dma_ack) begin
                chk("ack_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    chk("ack_port", {30'd0, dma_ack, cpu_ack},
                        cur.dma ? 2 : 1);
                    chk("ack_gnt", 32'(gnt), cur.dma ? 2 : 1);
                    chk("ack_latency", 32'(cyc - g_cyc), LAT + 1);
                    chk("mem_en_cycles", 32'(en_cnt), LAT + 1);
                    chk("mem_we_cycles", 32'(we_cnt), 32'(cur.we));
                    chk("mem_en_done", 32'(mem_en), 0);
                    if (cur.dma) begin
                        if (!cur.we) last_dma = cur.rdata;
                        chk("dma_rdata", dma_rdata, last_dma);
                    end else begin
                        if (!cur.we) last_cpu = cur.rdata;
                        chk("cpu_rdata", cpu_rdata, last_cpu);
                    end
                end
                en_cnt = 0;
                we_cnt = 0;
            end
        end
        prev_gnt = rst ? 2'b00 : gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit dma, input bit we,
                        input logic [31:0] a, d, r);
        exp_t e;
        e.dma = dma;
        e.we = we;
        e.addr = a;
        e.wdata = d;
        e.rdata = r;
        sb.push_back(e);
    endtask

    task automatic access(input bit dma, input bit we,
                          input logic [31:0] a, d, r);
        int got = 0;
        push(dma, we, a, d, r);
        if (dma) begin
            dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
        for (int t = 0; t < 50 && got == 0; t++) begin
            tick();
            if (dma ? dma_ack : cpu_ack) got = 1;
        end
        cpu_req = 0;
        dma_req = 0;
        chk(dma ? "dma_ack_seen" : "cpu_ack_seen", 32'(got), 1);
        tick();
    endtask

    task automatic rst_outs(input string tag);
        chk({tag, "_ctl"},
            {27'd0, gnt, mem_en, mem_we, cpu_ack | dma_ack}, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_dma_rdata"}, dma_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        cpu_req = 0;
        dma_req = 0;
        sb.delete();
        repeat (2) tick();
        last_cpu = '0;
        last_dma = '0;
        rst_outs("reset");
        rst = 0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks[4];
        int got;
        int g;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4] = 32'hDEADBEEF;

        do_reset();

        // 1: CPU read of 0x10
        access(0, 0, 32'h10, 32'h0, 32'hDEADBEEF);

        // 2: DMA write then CPU read back
        access(1, 1, 32'h40, 32'h12345678, 32'h0);
        access(0, 0, 32'h40, 32'h0, 32'h12345678);

        // 3: simultaneous held requests, 4 accesses
        do_reset();
`ifdef MEM_ARB_RR_EN
        push(0, 0, 32'h10, 0, 32'hDEADBEEF);
        push(1, 0, 32'h40, 0, 32'h12345678);
        push(0, 0, 32'h10, 0, 32'hDEADBEEF);
        push(1, 0, 32'h40, 0, 32'h12345678);
`else
        for (int i = 0; i < 4; i++)
            push(0, 0, 32'h10, 0, 32'hDEADBEEF);
`endif
        cpu_we = 0; cpu_addr = 32'h10;
        dma_we = 0; dma_addr = 32'h40;
        cpu_req = 1;
        dma_req = 1;
        got = 0;
        for (int t = 0; t < 200 && got < 4; t++) begin
            tick();
            if (cpu_ack || dma_ack) begin
                acks[got] = cyc;
                got++;
                if (got == 4) begin
                    cpu_req = 0;
                    dma_req = 0;
                end
            end
        end
        cpu_req = 0;
        dma_req = 0;
        chk("tie_acks", 32'(got), 4);
        for (int i = 1; i < got; i++)
            chk("ack_period", 32'(acks[i] - acks[i-1]), LAT + 3);
        tick();
        chk("tie_sb_empty", 32'(sb.size()), 0);

        // 4: reset in 2nd BUSY cycle of a CPU write
        push(0, 1, 32'h80, 32'hCAFEF00D, 0);
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 32'h80; cpu_wdata = 32'hCAFEF00D;
        tick();
        tick();
        rst = 1;
        cpu_req = 0;
        sb.delete();
        tick();
        last_cpu = '0;
        last_dma = '0;
        rst_outs("abort");
        rst = 0;
        tick();
        access(0, 0, 32'h10, 32'h0, 32'hDEADBEEF);

        // 6: request dropped in first BUSY cycle
        push(0, 0, 32'h40, 0, 32'h12345678);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        tick();
        cpu_req = 0;
        got = 0;
        for (int t = 0; t < 50 && got == 0; t++) begin
            tick();
            if (cpu_ack) got = 1;
        end
        chk("drop_ack_seen", 32'(got), 1);
        g = 0;
        repeat (6) begin
            tick();
            if (gnt != 2'b00) g++;
        end
        chk("drop_no_regrant", 32'(g), 0);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
